// File: rtl/alphabet_pkg.sv
// Shared definitions for the alphabet grading map: widths, code constants,
// enumerator states and the forward map function.
package alphabet_pkg;

  localparam int D_W    = 6;
  localparam int S_W    = 3;
  localparam int CODE_W = 5;
  localparam int IDX_W  = D_W + S_W;

  localparam logic [CODE_W-1:0] CODE_NONE = 5'd0;
  localparam logic [CODE_W-1:0] CODE_A    = 5'd1;
  localparam logic [CODE_W-1:0] CODE_B    = 5'd2;
  localparam logic [CODE_W-1:0] CODE_C    = 5'd3;
  localparam logic [CODE_W-1:0] CODE_D    = 5'd4;
  localparam logic [CODE_W-1:0] CODE_E    = 5'd5;
  localparam logic [CODE_W-1:0] CODE_F    = 5'd6;
  localparam logic [CODE_W-1:0] CODE_G    = 5'd7;
  localparam logic [CODE_W-1:0] CODE_H    = 5'd8;
  localparam logic [CODE_W-1:0] CODE_I    = 5'd9;
  localparam logic [CODE_W-1:0] CODE_J    = 5'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_HOLD
  } state_t;

  // S values 6 and 7 are outside every graded band, hence the outer guard.
  function automatic logic [CODE_W-1:0] alphabet_map(input logic [D_W-1:0] d,
                                                     input logic [S_W-1:0] s);
    logic [CODE_W-1:0] c;
    c = CODE_NONE;
    if (s <= 3'd5) begin
      if (d >= 6'd1 && d <= 6'd5)        c = d[CODE_W-1:0];
      else if (d >= 6'd6 && d <= 6'd7)   c = CODE_F;
      else if (d >= 6'd8 && d <= 6'd10)  c = (s == 3'd0) ? CODE_G : CODE_H;
      else if (d >= 6'd11 && d <= 6'd13) c = (s == 3'd0) ? CODE_I : CODE_J;
    end
    return c;
  endfunction

endpackage

// File: rtl/alphabet_map_comb.sv
// Combinational forward alphabet map: (d, s) -> code.
module alphabet_map_comb
  import alphabet_pkg::*;
(
  input  logic [D_W-1:0]    d,
  input  logic [S_W-1:0]    s,
  output logic [CODE_W-1:0] code
);

  assign code = alphabet_map(d, s);

endmodule

// File: rtl/alphabet_enum.sv
// Reverse-lookup enumerator: scans every {D,S} in ascending order and streams
// the pairs whose alphabet code equals the requested one, then pulses done.
module alphabet_enum
  import alphabet_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CODE_W-1:0] req_code,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [D_W-1:0]    out_d,
  output logic [S_W-1:0]    out_s,
  output logic              done,
  output logic [8:0]        match_count
);

  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] map_code;

  alphabet_map_comb u_map (
    .d    (idx[IDX_W-1:S_W]),
    .s    (idx[S_W-1:0]),
    .code (map_code)
  );

  assign req_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      code        <= '0;
      out_valid   <= 1'b0;
      out_d       <= '0;
      out_s       <= '0;
      done        <= 1'b0;
      match_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            code        <= req_code;
            idx         <= '0;
            match_count <= '0;
            state       <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (map_code == code) begin
            out_d       <= idx[IDX_W-1:S_W];
            out_s       <= idx[S_W-1:0];
            out_valid   <= 1'b1;
            match_count <= match_count + 9'd1;
            state       <= ST_HOLD;
          end else if (idx == IDX_LAST) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_HOLD: begin
          // Abort beats a simultaneous handshake; the pair still counts as delivered.
          if (abort) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == IDX_LAST) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_SCAN;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alphabet_enum.sv
// Scoreboard bench for alphabet_enum: directed requests push expected pairs,
// a negedge monitor pops and compares on every output handshake.
module tb_alphabet_enum;
  import alphabet_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [CODE_W-1:0] req_code = '0;
  logic              abort = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [D_W-1:0]    out_d;
  logic [S_W-1:0]    out_s;
  logic              done;
  logic [8:0]        match_count;

  int n_cmp = 0;
  int n_fail = 0;
  int hs_count = 0;
  logic stall_mode = 1'b0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  alphabet_enum dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_code    (req_code),
    .abort       (abort),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_d       (out_d),
    .out_s       (out_s),
    .done        (done),
    .match_count (match_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  // Monitor: pops one expected pair per handshake, checks stability while stalled.
  logic       prev_stall = 1'b0;
  logic [8:0] prev_pair = '0;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (prev_stall) check("stall_stable", {out_d, out_s}, prev_pair);
      if (out_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_pair: actual d=%0d s=%0d required none", out_d, out_s);
        end else begin
          check("pair", {out_d, out_s}, exp_q.pop_front());
        end
      end
      prev_stall = !out_ready;
      prev_pair  = {out_d, out_s};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_ds(input int dlo, input int dhi, input int slo, input int shi);
    for (int d = dlo; d <= dhi; d++)
      for (int s = slo; s <= shi; s++)
        exp_q.push_back({d[5:0], s[2:0]});
  endtask

  task automatic start(input logic [CODE_W-1:0] c);
    check("req_ready_before_accept", req_ready, 1);
    req_code  = c;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Returns edge offset of done relative to the accept edge, and of first out_valid.
  task automatic wait_done(input int budget, output int n, output int first_v);
    n = 0;
    first_v = -1;
    while (n < budget) begin
      @(posedge clk);
      n++;
      #1;
      if (out_valid && first_v < 0) first_v = n;
      out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) break;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: actual no done after %0d cycles required done", budget);
    end
  endtask

  task automatic finish_check(input string name, input int cnt);
    check({name, "_match_count"}, match_count, cnt);
    check({name, "_ready_in_done"}, req_ready, 1);
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int n, fv, guard;
    logic seen_done;

    // Reset state
    #12;
    check("rst_req_ready", req_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_match_count", match_count, 0);
    check("rst_out_d", out_d, 0);
    check("rst_out_s", out_s, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Code 1
    push_ds(1, 1, 0, 5);
    start(5'd1);
    wait_done(700, n, fv);
    check("c1_first_valid_edge", fv, 9);
    check("c1_done_edge", n, 518);
    finish_check("c1", 6);
    @(posedge clk); #1;
    check("c1_done_one_cycle", done, 0);

    // Code 6
    push_ds(6, 7, 0, 5);
    start(5'd6);
    wait_done(700, n, fv);
    check("c6_done_edge", n, 524);
    finish_check("c6", 12);
    @(posedge clk); #1;

    // Code 7 then code 8 accepted in the done cycle
    push_ds(8, 10, 0, 0);
    start(5'd7);
    wait_done(700, n, fv);
    check("c7_done_high", done, 1);
    finish_check("c7", 3);
    push_ds(8, 10, 1, 5);
    start(5'd8);
    wait_done(700, n, fv);
    check("c8_done_edge", n, 527);
    finish_check("c8", 15);
    @(posedge clk); #1;

    // Code 20: never matches
    start(5'd20);
    wait_done(700, n, fv);
    check("c20_done_edge", n, 512);
    check("c20_no_valid", fv, -1);
    finish_check("c20", 0);
    @(posedge clk); #1;

    // Code 0: everything outside D 1..13 with S 0..5
    for (int d = 0; d < 64; d++)
      for (int s = 0; s < 8; s++)
        if (!(d >= 1 && d <= 13 && s <= 5)) exp_q.push_back({d[5:0], s[2:0]});
    start(5'd0);
    wait_done(1500, n, fv);
    check("c0_done_edge", n, 946);
    finish_check("c0", 434);
    @(posedge clk); #1;

    // Code 10 with random stalls
    stall_mode = 1'b1;
    push_ds(11, 13, 1, 5);
    start(5'd10);
    wait_done(4000, n, fv);
    stall_mode = 1'b0;
    out_ready = 1'b1;
    finish_check("c10_stall", 15);
    @(posedge clk); #1;

    // Code 6 aborted after the third pair
    push_ds(6, 7, 0, 5);
    guard = hs_count + 3;
    start(5'd6);
    n = 0;
    while (hs_count < guard && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reached_third", hs_count, guard);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle", req_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_no_done", done, 0);
    check("abort_match_count", match_count, 3);
    check("abort_undelivered", exp_q.size(), 9);
    exp_q.delete();
    seen_done = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || out_valid) seen_done = 1'b1;
    end
    check("abort_stays_idle", seen_done, 0);

    // Reset asserted while holding a pair
    out_ready = 1'b0;
    exp_q.push_back({6'd1, 3'd0});
    start(5'd1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_reached", out_valid, 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_d", out_d, 0);
    check("async_rst_out_s", out_s, 0);
    check("async_rst_done", done, 0);
    check("async_rst_match_count", match_count, 0);
    check("async_rst_req_ready", req_ready, 1);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Recovery after reset
    push_ds(1, 1, 0, 5);
    start(5'd1);
    wait_done(700, n, fv);
    finish_check("post_rst_c1", 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
